// File: rtl/prng_pkg.sv
// Shared definitions for the Keccak-f[200] sponge PRNG.
// Holds the lane width, the round count, the FSM encoding, the round-constant
// and rho-offset tables, and a single combinational theta-rho-pi-chi-iota round.
package prng_pkg;

  localparam int unsigned LANE_W  = 8;
  localparam int unsigned LANES   = 25;
  localparam int unsigned STATE_W = LANE_W * LANES;
  localparam int unsigned ROUNDS  = 18;
  localparam int unsigned RND_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PERM      = 2'd1,
    ST_READY     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } prng_state_e;

  // Iota constants: low byte of the Keccak-f[1600] constants for rounds 0..17.
  function automatic logic [7:0] round_const(input logic [RND_W-1:0] idx);
    logic [7:0] rc;
    case (idx)
      5'd0:    rc = 8'h01;
      5'd1:    rc = 8'h82;
      5'd2:    rc = 8'h8A;
      5'd3:    rc = 8'h00;
      5'd4:    rc = 8'h8B;
      5'd5:    rc = 8'h01;
      5'd6:    rc = 8'h81;
      5'd7:    rc = 8'h09;
      5'd8:    rc = 8'h8A;
      5'd9:    rc = 8'h88;
      5'd10:   rc = 8'h09;
      5'd11:   rc = 8'h0A;
      5'd12:   rc = 8'h8B;
      5'd13:   rc = 8'h8B;
      5'd14:   rc = 8'h89;
      5'd15:   rc = 8'h03;
      5'd16:   rc = 8'h02;
      5'd17:   rc = 8'h80;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Rho offsets reduced mod 8, indexed by lane x + 5*y.
  function automatic logic [2:0] rho_off(input int unsigned lane);
    logic [2:0] r;
    case (lane)
      0:       r = 3'd0;
      1:       r = 3'd1;
      2:       r = 3'd6;
      3:       r = 3'd4;
      4:       r = 3'd3;
      5:       r = 3'd4;
      6:       r = 3'd4;
      7:       r = 3'd6;
      8:       r = 3'd7;
      9:       r = 3'd4;
      10:      r = 3'd3;
      11:      r = 3'd2;
      12:      r = 3'd3;
      13:      r = 3'd1;
      14:      r = 3'd7;
      15:      r = 3'd1;
      16:      r = 3'd5;
      17:      r = 3'd7;
      18:      r = 3'd5;
      19:      r = 3'd0;
      20:      r = 3'd2;
      21:      r = 3'd2;
      22:      r = 3'd5;
      23:      r = 3'd0;
      24:      r = 3'd6;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // One Keccak-f[200] round. Lane i = x + 5*y sits at state[199-8i -: 8], bit 0 = LSB.
  function automatic logic [STATE_W-1:0] keccak_round(input logic [STATE_W-1:0] s,
                                                       input logic [7:0]         rc);
    logic [7:0] a  [LANES];
    logic [7:0] th [LANES];
    logic [7:0] b  [LANES];
    logic [7:0] c  [5];
    logic [7:0] d  [5];
    logic [STATE_W-1:0] r;
    for (int i = 0; i < 25; i++) begin
      a[i] = s[199-8*i -: 8];
      b[i] = 8'h00;
    end
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl8(c[(x+1)%5], 3'd1);
    for (int i = 0; i < 25; i++) th[i] = a[i] ^ d[i%5];
    // rho + pi: lane (x,y) moves to (y, 2x+3y)
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y + 5*((2*x + 3*y) % 5)] = rotl8(th[x + 5*y], rho_off(x + 5*y));
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[199-8*(x+5*y) -: 8] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
    r[199 -: 8] = r[199 -: 8] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/keccak_f200_core.sv
// Iterative Keccak-f[200] permutation, one round per clock, 18 rounds.
// Ports: clk, rst (sync, active-high), start (accepted when idle),
//        state_in (latched with round 0), busy, done (1-cycle pulse after
//        round 17), state_out (permutation result, valid while done is high
//        and held afterwards).
module keccak_f200_core
  import prng_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);

  logic [STATE_W-1:0] st_q, st_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [STATE_W-1:0] rnd_in_c, rnd_out_c;
  logic [RND_W-1:0]   rnd_idx_c;

  // Round 0 is computed directly from state_in in the start cycle.
  always_comb begin
    rnd_in_c  = busy_q ? st_q : state_in;
    rnd_idx_c = busy_q ? rnd_q : '0;
    rnd_out_c = keccak_round(rnd_in_c, round_const(rnd_idx_c));
    st_d      = st_q;
    rnd_d     = rnd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (busy_q) begin
      st_d = rnd_out_c;
      if (rnd_q == RND_W'(ROUNDS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        rnd_d  = '0;
      end else begin
        rnd_d = rnd_q + RND_W'(1);
      end
    end else if (start) begin
      st_d   = rnd_out_c;
      rnd_d  = RND_W'(1);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '0;
      rnd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = st_q;

endmodule

// File: rtl/prng_sponge.sv
// Keccak-f[200] sponge PRNG: absorbs a byte-aligned seed, squeezes one
// OUT_W-bit word per permutation, and demands a reseed after MAX_WORDS words.
// Ports: clk, rst (sync, active-high); seed_valid/seed_ready/seed/seed_mod
//        (seed handshake, seed_mod=0 absorbs zeros); rng_valid/rng_ready/
//        rng_data (word handshake); reseed_req (unseeded or budget spent);
//        rng_err (sticky repeated-word flag).
// Build option: PRNG_HEALTH_EN enables the repeated-word health check;
//               without it rng_err is tied low.
module prng_sponge
  import prng_pkg::*;
#(
  parameter int unsigned SEED_W    = 96,
  parameter int unsigned OUT_W     = 96,
  parameter int unsigned RATE      = 96,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [SEED_W-1:0] seed,
  input  logic              seed_mod,
  output logic              rng_valid,
  input  logic              rng_ready,
  output logic [OUT_W-1:0]  rng_data,
  output logic              reseed_req,
  output logic              rng_err
);

  localparam int unsigned SEED_BYTES = SEED_W / 8;

  prng_state_e        state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               seed_ready_q, seed_ready_d;
  logic               rng_valid_q, rng_valid_d;
  logic               reseed_req_q, reseed_req_d;

  logic               seed_hs_c, rng_hs_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [STATE_W-1:0] absorb_c;
  logic               core_start_c;
  logic [STATE_W-1:0] core_in_c;
  logic               core_busy, core_done;
  logic [STATE_W-1:0] core_out;

`ifdef PRNG_HEALTH_EN
  logic [OUT_W-1:0]   prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic               err_q, err_d;
`endif

  // Padded seed: zero state, seed bytes from the top, 0x01 after the seed,
  // 0x80 in the last rate byte.
  always_comb begin
    absorb_c = '0;
    for (int b = 0; b < int'(SEED_BYTES); b++)
      absorb_c[199-8*b -: 8] = seed_mod ? seed[8*b +: 8] : 8'h00;
    absorb_c[199-8*SEED_BYTES -: 8] = absorb_c[199-8*SEED_BYTES -: 8] ^ 8'h01;
    absorb_c[199-RATE+8 -: 8]       = absorb_c[199-RATE+8 -: 8] ^ 8'h80;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    core_start_c = 1'b0;
    core_in_c    = s_q;
    seed_hs_c    = seed_valid && (state_q != ST_PERM) && !core_busy;
    rng_hs_c     = rng_ready && (state_q == ST_READY);
    cnt_inc_c    = cnt_q + CNT_W'(1);
`ifdef PRNG_HEALTH_EN
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    err_d        = err_q;
`endif

    case (state_q)
      ST_PERM: begin
        if (core_done) begin
          s_d     = core_out;
          data_d  = core_out[199 -: OUT_W];
          state_d = ST_READY;
`ifdef PRNG_HEALTH_EN
          if (have_prev_q && (core_out[199 -: OUT_W] == prev_q)) err_d = 1'b1;
          prev_d      = core_out[199 -: OUT_W];
          have_prev_d = 1'b1;
`endif
        end
      end
      ST_READY: begin
        if (rng_hs_c) begin
          cnt_d = cnt_inc_c;
          if ((MAX_WORDS != 0) && (cnt_inc_c == CNT_W'(MAX_WORDS))) begin
            state_d = ST_EXHAUSTED;
          end else begin
            core_start_c = 1'b1;
            core_in_c    = s_q;
            state_d      = ST_PERM;
          end
        end
      end
      default: ;
    endcase

    // A seed handshake wins over a same-cycle word handshake.
    if (seed_hs_c) begin
      s_d          = absorb_c;
      cnt_d        = '0;
      core_start_c = 1'b1;
      core_in_c    = absorb_c;
      state_d      = ST_PERM;
`ifdef PRNG_HEALTH_EN
      prev_d       = '0;
      have_prev_d  = 1'b0;
      err_d        = 1'b0;
`endif
    end

    seed_ready_d = (state_d != ST_PERM);
    rng_valid_d  = (state_d == ST_READY);
    reseed_req_d = (state_d == ST_IDLE) || (state_d == ST_EXHAUSTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      seed_ready_q <= 1'b1;
      rng_valid_q  <= 1'b0;
      reseed_req_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      seed_ready_q <= seed_ready_d;
      rng_valid_q  <= rng_valid_d;
      reseed_req_q <= reseed_req_d;
    end
  end

`ifdef PRNG_HEALTH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
    end
  end
  assign rng_err = err_q;
`else
  assign rng_err = 1'b0;
`endif

  keccak_f200_core u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start_c),
    .state_in  (core_in_c),
    .busy      (core_busy),
    .done      (core_done),
    .state_out (core_out)
  );

  assign seed_ready = seed_ready_q;
  assign rng_valid  = rng_valid_q;
  assign rng_data   = data_q;
  assign reseed_req = reseed_req_q;

endmodule

// File: doc/prng_sponge.md
# prng_sponge

Parametrised Keccak-f[200] sponge pseudo-random generator for the ROLLO encrypt datapath. It absorbs a byte-aligned seed into the rate portion of a 200-bit state and squeezes a stream of OUT_W-bit words, one permutation per word, over ready/valid handshakes. A word budget forces periodic reseeding. It sits between the seed source and the error-vector/sampling logic.

## Interface
- SEED_W, 96: seed width in bits; multiple of 8, at most RATE.
- OUT_W, 96: output word width; at most RATE.
- RATE, 96: sponge rate in bits; multiple of 8, at most 192.
- MAX_WORDS, 1024: words per seed before a reseed is mandatory; 0 means unlimited.
- CNT_W, 16: width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  seed accepted when high with seed_valid.
- seed  in  SEED_W  seed value; byte b occupies bits 8b+7:8b.
- seed_mod  in  1  1: absorb `seed`; 0: absorb an all-zero seed (deterministic test mode).
- rng_valid  out  1  rng_data holds a fresh word.
- rng_ready  in  1  consumer takes the word.
- rng_data  out  OUT_W  output word = state[199 -: OUT_W].
- reseed_req  out  1  generator is unseeded or the word budget is exhausted.
- rng_err  out  1  sticky health-test failure (see Configuration).

## Operation
- State: 200-bit register S, cleared by reset.
- FSM states: IDLE, PERM, READY, EXHAUSTED.
- IDLE: seed_ready=1; on seed handshake go to PERM.
- Absorb: S <= 0, then XOR seed byte b into S[199-8b : 192-8b]; XOR 0x01 into the byte following the seed; XOR 0x80 into the last rate byte, S[199-RATE+8 : 199-RATE+1]. The word counter is cleared. Every seed, including a reseed, restarts from the zero state.
- PERM: start the core. On core done, load S, go to READY.
- READY: rng_valid=1, seed_ready=1.
  - On rng handshake: the word counter increments. If the new count equals MAX_WORDS (MAX_WORDS≠0), go to EXHAUSTED. Otherwise re-permute S (PERM).
  - On a seed handshake, a fresh absorb occurs and the state goes to PERM.
  - If both handshakes occur in the same cycle, the word counts as consumed and the seed is absorbed.
- EXHAUSTED: rng_valid=0, reseed_req=1, seed_ready=1. A seed handshake absorbs the seed and goes to PERM.
- PERM: seed_ready=0 and rng_valid=0. seed_valid is ignored.
- reseed_req=1 in IDLE and EXHAUSTED, 0 otherwise.
- rng_data holds its last value outside READY and is 0 after reset.

## Timing
- Reset values: seed_ready=1, rng_valid=0, rng_data=0, reseed_req=1, rng_err=0. The FSM is in IDLE, S=0, and the counter is 0.
- The core runs one round per cycle for 18 rounds.
- Seed handshake in cycle t: rng_valid is high from cycle t+19.
- rng handshake in cycle c: the next rng_valid is high from c+19, unless the budget is exhausted.
- Throughput: one word per 19 cycles.
- rng_valid and rng_data are stable until handshake; a producer-side withdraw is never performed.
- Reset asserted mid-permutation aborts the core. All outputs return to reset values on the next edge.

## Configuration
- PRNG_HEALTH_EN, defined: an OUT_W-bit register keeps the previous word. When a new word enters READY equal to the previous word, rng_err sets in the same cycle as rng_valid. It stays set until rst or the next seed handshake. The register is cleared at absorb, and the first word after a seed is never compared.
- PRNG_HEALTH_EN, undefined: no comparison register; rng_err is tied to 0.

## Structure
- Shared package (prng_pkg): the 18 Keccak-f[200] 8-bit round constants, the rotation-offset table, the lane width (8), the round count (18), and the FSM state encoding.
- Sub-module keccak_f200_core.
  - Inputs: clk, rst, start, state_in[199:0].
  - Outputs: busy, done (one-cycle pulse), state_out[199:0].
  - Contains a 5-bit round counter and computes one θ-ρ-π-χ-ι round per cycle.
- The top holds the FSM, absorb/pad logic, word counter and health register.

## Test plan
- Reset then seed_mod=0, seed_valid pulse: rng_valid rises exactly 19 cycles later; rng_data equals the golden Keccak-f[200] output of the padded zero state from the software model.
- seed=96'h0102…0C, rng_ready held 1 for 5 words: five words match the model, spaced 19 cycles apart, and reseed_req stays 0.
- MAX_WORDS=3: after the 3rd handshake, rng_valid=0, reseed_req=1, and FSM is EXHAUSTED. A new seed restarts output 19 cycles later with the counter at 0.
- seed_valid and rng_ready both high in READY: the word is counted, the new seed is absorbed, and the next word matches the model for the new seed alone.
- rst pulsed at round 9 of PERM: all outputs are at reset values next cycle, and a subsequent seed gives the normal result.
- PRNG_HEALTH_EN defined, core forced (bench override) to repeat a word: rng_err=1 with the second word; it clears on the next seed handshake. With the macro undefined, rng_err stays 0.
